tick_scheduler: RTL and testbench

Shared tick scheduler for the input-control path. A single prescaler divides the system clock down to a base tick rate. NCH independent channels each derive a programmable periodic or one-shot tick from that base tick, so several consumers (debounce, scan, blink, timeout) share one divider instead of each instantiating its own. Channels are configured through a valid/ready command port.

---
 rtl/tick_scheduler.sv | 103 ++++++++++
 tb/tb_tick_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Shared prescaler plus NCH programmable periodic/one-shot tick channels; tick_out/busy land 1 clk after the deciding base_tick.
// cfg_ready is registered and drops only in base_tick cycles, so a command never races a channel update.
module tick_scheduler #(
  parameter int CLK_HZ  = 50000000,
  parameter int BASE_HZ = 1000,
  parameter int NCH     = 4,
  parameter int DIVW    = 16,
  parameter int CHW     = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [1:0]      cfg_cmd,
  input  logic            cfg_mode,
  input  logic [DIVW-1:0] cfg_div,
  output logic            base_tick,
  output logic [NCH-1:0]  busy,
  output logic [NCH-1:0]  tick_out
);

  localparam int PRE = CLK_HZ / BASE_HZ;
  localparam int PW  = (PRE > 2) ? $clog2(PRE) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE - 1);
  localparam logic [1:0]    CMD_START = 2'b01;
  localparam logic [1:0]    CMD_STOP  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  logic [PW-1:0]   pre_cnt;
  logic [PW-1:0]   pre_nxt;
  logic            cmd_acc;
  logic [DIVW-1:0] div_load;

  assign pre_nxt   = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
  assign base_tick = (pre_cnt == PRE_LAST);
  assign cmd_acc   = cfg_valid && cfg_ready;
  assign div_load  = (cfg_div == '0) ? DIVW'(1) : cfg_div;

  // cfg_ready looks one cycle ahead so it is low exactly while base_tick is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      cfg_ready <= 1'b0;
    end else begin
      pre_cnt   <= pre_nxt;
      cfg_ready <= (pre_nxt != PRE_LAST);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_t       st;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div;
    logic            mode;
    logic            tick_q;
    logic            sel;

    assign sel = cmd_acc && (cfg_ch == CHW'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= IDLE;
        cnt    <= '0;
        div    <= '0;
        mode   <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (sel && cfg_cmd == CMD_START) begin
          // Restart discards the current phase; counting resumes from the next base_tick.
          div  <= div_load;
          cnt  <= div_load;
          mode <= cfg_mode;
          st   <= RUN;
        end else if (sel && cfg_cmd == CMD_STOP) begin
          st  <= IDLE;
          cnt <= '0;
        end else if (st == RUN && base_tick) begin
          if (cnt == DIVW'(1)) begin
            tick_q <= 1'b1;
            if (mode) begin
              st  <= IDLE;
              cnt <= '0;
            end else begin
              cnt <= div;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end

    assign busy[i]     = (st == RUN);
    assign tick_out[i] = tick_q;
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed stimulus with a per-channel queue of expected tick cycles; a negedge monitor pops and compares.
module tb_tick_scheduler;
  localparam int NCH  = 4;
  localparam int DIVW = 8;
  localparam int CHW  = 2;
  localparam int PRE  = 10;
  localparam int HORIZON = 1000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch = '0;
  logic [1:0]      cfg_cmd = '0;
  logic            cfg_mode = 1'b0;
  logic [DIVW-1:0] cfg_div = '0;
  logic            base_tick;
  logic [NCH-1:0]  busy;
  logic [NCH-1:0]  tick_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int expq[NCH][$];

  tick_scheduler #(
    .CLK_HZ(100), .BASE_HZ(10), .NCH(NCH), .DIVW(DIVW), .CHW(CHW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_cmd(cfg_cmd), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .base_tick(base_tick), .busy(busy), .tick_out(tick_out)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: cycle c lies between posedge c and posedge c+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_base_tick", base_tick, 0);
      check("rst_cfg_ready", cfg_ready, 0);
      check("rst_tick_out", tick_out, 0);
      check("rst_busy", busy, 0);
    end else begin
      check("base_tick", base_tick, (cyc % PRE) == PRE - 1);
      check("cfg_ready", cfg_ready, (cyc >= 1) && ((cyc % PRE) != PRE - 1));
      for (int ch = 0; ch < NCH; ch++) begin
        while (expq[ch].size() > 0 && expq[ch][0] < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_tick ch%0d: got none expected pulse at cyc %0d", ch, expq[ch][0]);
          void'(expq[ch].pop_front());
        end
        if (tick_out[ch]) begin
          if (expq[ch].size() == 0) begin
            check($sformatf("unexpected_tick_ch%0d", ch), cyc, -1);
          end else begin
            check($sformatf("tick_cycle_ch%0d", ch), cyc, expq[ch][0]);
            void'(expq[ch].pop_front());
          end
        end
      end
    end
  end

  task automatic wait_until(input int c);
    for (int k = 0; k < 5000 && cyc < c; k++) @(negedge clk);
    if (cyc < c) check("wait_timeout", cyc, c);
  endtask

  // Returns at the negedge of the acceptance cycle; acc is the posedge number that took the command.
  task automatic send(input int ch, input logic [1:0] cmd, input logic mode,
                      input logic [DIVW-1:0] div, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    cfg_ch    = CHW'(ch);
    cfg_cmd   = cmd;
    cfg_mode  = mode;
    cfg_div   = div;
    cfg_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = cfg_ready;
      @(posedge clk);
      #1;
      if (ok) acc = cyc;
      else    @(negedge clk);
    end
    if (!ok) check("cfg_accept_timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Ticks appear in the cycle after a base_tick edge; base_tick edges are posedges 10,20,30...
  task automatic expect_start(input int ch, input int acc, input int div, input bit one_shot);
    int d;
    int t;
    d = (div == 0) ? 1 : div;
    t = ((acc + PRE - 1) / PRE + d - 1) * PRE;
    expq[ch].delete();
    if (one_shot) begin
      expq[ch].push_back(t);
    end else begin
      while (t <= HORIZON) begin
        expq[ch].push_back(t);
        t += d * PRE;
      end
    end
  endtask

  initial begin
    int a;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    wait_until(40);
    check("idle_busy", busy, 0);
    check("idle_tick", tick_out, 0);

    // Periodic ch0, div=3: first tick at 70, then every 30.
    wait_until(42);
    send(0, 2'b01, 1'b0, 8'd3, a);
    expect_start(0, a, 3, 1'b0);
    check("ch0_accept_cyc", a, 43);
    check("ch0_busy_after_start", busy[0], 1);

    // One-shot ch1 with div=0 behaves as div=1: single tick at 80, busy drops with it.
    wait_until(75);
    send(1, 2'b01, 1'b1, 8'd0, a);
    expect_start(1, a, 0, 1'b1);
    check("ch1_busy_after_start", busy[1], 1);
    wait_until(79);
    check("ch1_busy_before_tick", busy[1], 1);
    wait_until(80);
    check("ch1_tick_at_80", tick_out[1], 1);
    check("ch1_busy_drops_with_tick", busy[1], 0);

    // Command offered in a base_tick cycle waits one cycle; ch3 div=2 ticks at 210, 230, ...
    wait_until(189);
    check("collision_ready_low", cfg_ready, 0);
    send(3, 2'b01, 1'b0, 8'd2, a);
    check("collision_accept_cyc", a, 191);
    expect_start(3, a, 2, 1'b0);

    // ch2 div=4 would tick at 260; restart with div=2 after 3 base ticks moves it to 270.
    wait_until(222);
    send(2, 2'b01, 1'b0, 8'd4, a);
    expect_start(2, a, 4, 1'b0);
    wait_until(252);
    send(2, 2'b01, 1'b0, 8'd2, a);
    expect_start(2, a, 2, 1'b0);
    check("ch2_busy_after_restart", busy[2], 1);
    wait_until(275);
    send(2, 2'b10, 1'b0, 8'd0, a);
    expq[2].delete();
    check("ch2_busy_after_stop", busy[2], 0);

    // Stop on an idle channel and both no-op encodings leave everything untouched.
    wait_until(282);
    send(1, 2'b10, 1'b0, 8'd0, a);
    check("stop_idle_ch1_busy", busy[1], 0);
    send(0, 2'b00, 1'b1, 8'd5, a);
    send(0, 2'b11, 1'b1, 8'd5, a);
    wait_until(300);
    check("busy_before_reset", busy, 4'b1001);

    // Async reset between base ticks; pending ticks at 310 must vanish.
    wait_until(305);
    #2 rst_n = 1'b0;
    for (int ch = 0; ch < NCH; ch++) expq[ch].delete();
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_tick", tick_out, 0);
    check("async_rst_ready", cfg_ready, 0);
    check("async_rst_base_tick", base_tick, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    wait_until(100);
    check("post_rst_busy", busy, 0);

    // Fresh start after reset: ch3 div=1 ticks at 110, 120, ...
    wait_until(102);
    send(3, 2'b01, 1'b0, 8'd1, a);
    expect_start(3, a, 1, 1'b0);
    check("ch3_busy_after_restart", busy[3], 1);
    wait_until(115);
    check("ch3_still_busy", busy[3], 1);
    wait_until(160);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
